// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with valid/ready handshake.
// It has an optional two-entry skid buffer and a synchronous flush to NOP.
// It also keeps saturating counters for stall cycles and for flushes that discard data.
module pipe_stage_elastic #(
    parameter int unsigned       DATA_W    = 64,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter bit                SKID      = 1'b1,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              in_xfer;
    logic              out_xfer;

    // The main register holds NOP whenever the stage is empty.
    // This lets out_data come straight from the register.
    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_q;
    // With a skid buffer, in_ready is registered to break the out_ready -> in_ready path.
    assign in_ready  = SKID ? in_ready_q : (!out_valid || out_ready);
    assign in_xfer   = in_valid && in_ready && !flush;
    assign out_xfer  = out_valid && out_ready;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

    // Next-state and payload movement; flush overrides any handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        state_d = StOne;
                        main_d  = in_data;
                    end
                end
                StOne: begin
                    // Without a skid buffer, in_ready is low in this case, so StTwo cannot be reached.
                    if (in_xfer && !out_xfer) begin
                        state_d = StTwo;
                        skid_d  = in_data;
                    end else if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (out_xfer) begin
                        state_d = StEmpty;
                        main_d  = NOP_VALUE;
                    end
                end
                StTwo: begin
                    if (out_xfer) begin
                        state_d = StOne;
                        main_d  = skid_q;
                        skid_d  = NOP_VALUE;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end
            endcase
        end
    end

    // Saturating event counters; a stall still counts in a flush cycle.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (out_valid && !out_ready && (stall_q != CntMax)) begin
            stall_d = stall_q + 1'b1;
        end
        if (flush && out_valid && (flush_q != CntMax)) begin
            flush_d = flush_q + 1'b1;
        end
    end

    // State, payload and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            main_q     <= NOP_VALUE;
            skid_q     <= NOP_VALUE;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != StTwo);
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic.
// It runs two instances: a skid build (CNT_W=16) and a single-entry build (CNT_W=4).
// Both get the same stimulus; sel picks the instance being checked.
// The reference model is a queue of held beats.
module tb_pipe_stage_elastic;

    localparam logic [63:0] NOP = 64'h0000_0013_0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid;
    logic [63:0] a_out_data;
    logic [15:0] a_stall, a_flush;
    logic        b_in_ready, b_out_valid;
    logic [63:0] b_out_data;
    logic [3:0]  b_stall, b_flush;

    bit          sel = 1'b0;
    logic        o_valid, o_ready;
    logic [63:0] o_data;
    int          o_stall, o_flush;

    int          errors = 0;
    int          checks = 0;

    logic [63:0] mq[$];
    int          m_stall = 0;
    int          m_flush = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(64), .NOP_VALUE(NOP), .SKID(1'b1), .CNT_W(16)) u_skid (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .stall_cnt(a_stall), .flush_cnt(a_flush)
    );

    pipe_stage_elastic #(.DATA_W(64), .NOP_VALUE(NOP), .SKID(1'b0), .CNT_W(4)) u_single (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .stall_cnt(b_stall), .flush_cnt(b_flush)
    );

    // Observe the instance under test.
    always_comb begin
        o_valid = sel ? b_out_valid : a_out_valid;
        o_ready = sel ? b_in_ready : a_in_ready;
        o_data  = sel ? b_out_data : a_out_data;
        o_stall = sel ? int'(b_stall) : int'(a_stall);
        o_flush = sel ? int'(b_flush) : int'(a_flush);
    end

    function automatic int cmax();
        return sel ? 15 : 65535;
    endfunction

    function automatic bit m_in_ready();
        if (sel) return (mq.size() == 0) || out_ready;
        return mq.size() < 2;
    endfunction

    function automatic logic [63:0] m_data();
        if (mq.size() != 0) return mq[0];
        return NOP;
    endfunction

    task automatic drive(input bit iv, input logic [63:0] d, input bit ordy, input bit fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    // Advance the model by one cycle using the current inputs, then clock the DUT.
    task automatic tick(output bit acc);
        bit ov;
        ov  = (mq.size() != 0);
        acc = in_valid && m_in_ready() && !flush;
        if (ov && !out_ready && m_stall < cmax()) m_stall++;
        if (flush) begin
            if (ov && m_flush < cmax()) m_flush++;
            mq.delete();
        end else begin
            if (ov && out_ready) void'(mq.pop_front());
            if (acc) mq.push_back(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_stall = 0;
        m_flush = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            #1;
            checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid sel=%0d: got %b want 0", s, o_valid); end
            checks++; if (o_data !== NOP) begin errors++; $display("FAIL reset_data sel=%0d: got %h want %h", s, o_data, NOP); end
            checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready sel=%0d: got %b want 1", s, o_ready); end
            checks++; if (o_stall != 0 || o_flush != 0) begin errors++; $display("FAIL reset_counters sel=%0d: got %0d/%0d want 0/0", s, o_stall, o_flush); end
        end
        rst_n = 1'b1;
        sel = 1'b0;
    endtask

    task automatic test_single_beat(input bit s);
        bit acc;
        sel = s;
        do_reset();
        drive(1'b1, {32'hA5A5_0004, 32'h0000_0020}, 1'b1, 1'b0);
        checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL single_pre sel=%0d: ready/valid %b/%b want 1/0", s, o_ready, o_valid); end
        tick(acc);
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL single_valid sel=%0d: got %b want 1", s, o_valid); end
        checks++; if (o_data !== 64'hA5A5_0004_0000_0020) begin errors++; $display("FAIL single_data sel=%0d: got %h want a5a5000400000020", s, o_data); end
        tick(acc);
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (o_valid !== 1'b0 || o_data !== NOP) begin errors++; $display("FAIL single_empty sel=%0d: valid %b data %h want 0 %h", s, o_valid, o_data, NOP); end
    endtask

    task automatic test_skid_fill();
        logic [63:0] beats [3];
        int k;
        bit acc;
        beats = '{64'd1, 64'd2, 64'd3};
        k = 0;
        sel = 1'b0;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(k < 3, beats[k > 2 ? 2 : k], 1'b0, 1'b0);
            if (c >= 2) begin
                checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL skid_in_ready c=%0d: got %b want 0", c, o_ready); end
            end
            tick(acc);
            if (acc) k++;
        end
        for (int j = 0; j < 3; j++) begin
            drive(k < 3, beats[k > 2 ? 2 : k], 1'b1, 1'b0);
            checks++; if (o_valid !== 1'b1 || o_data !== beats[j]) begin errors++; $display("FAIL skid_order j=%0d: valid %b data %h want 1 %h", j, o_valid, o_data, beats[j]); end
            tick(acc);
            if (acc) k++;
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL skid_drained: valid %b want 0", o_valid); end
    endtask

    task automatic test_stream(input bit s, input int n);
        logic [63:0] cur;
        int sent, got, cyc;
        bit acc;
        sel = s;
        do_reset();
        cur = {$urandom, $urandom};
        sent = 0; got = 0; cyc = 0;
        while (sent < n && cyc < 1000) begin
            drive(1'b1, cur, 1'($urandom_range(0, 1)), 1'b0);
            checks++; if (o_valid !== (mq.size() != 0) || o_data !== m_data() || o_ready !== m_in_ready()) begin
                errors++; $display("FAIL stream sel=%0d cyc=%0d: v/r/d %b/%b/%h want %b/%b/%h", s, cyc, o_valid, o_ready, o_data, mq.size() != 0, m_in_ready(), m_data());
            end
            if (o_valid === 1'b1 && out_ready) got++;
            tick(acc);
            if (acc) begin sent++; cur = {$urandom, $urandom}; end
            cyc++;
        end
        checks++; if (sent != n) begin errors++; $display("FAIL stream_timeout sel=%0d: sent %0d want %0d", s, sent, n); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            checks++; if (o_valid !== (mq.size() != 0) || o_data !== m_data()) begin errors++; $display("FAIL stream_drain sel=%0d: v/d %b/%h want %b/%h", s, o_valid, o_data, mq.size() != 0, m_data()); end
            if (o_valid === 1'b1) got++;
            tick(acc);
        end
        checks++; if (got != n) begin errors++; $display("FAIL stream_count sel=%0d: got %0d beats want %0d", s, got, n); end
        checks++; if (o_stall != m_stall) begin errors++; $display("FAIL stream_stall sel=%0d: got %0d want %0d", s, o_stall, m_stall); end
    endtask

    task automatic test_flush(input bit s);
        bit acc;
        sel = s;
        do_reset();
        for (int i = 0; i < (s ? 1 : 2); i++) begin
            drive(1'b1, 64'h100 + 64'(i), 1'b0, 1'b0);
            tick(acc);
        end
        drive(1'b1, 64'd7, 1'b0, 1'b1);
        tick(acc);
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (o_valid !== 1'b0 || o_data !== NOP) begin errors++; $display("FAIL flush_out sel=%0d: valid %b data %h want 0 %h", s, o_valid, o_data, NOP); end
        checks++; if (o_flush != 1) begin errors++; $display("FAIL flush_cnt sel=%0d: got %0d want 1", s, o_flush); end
        checks++; if (o_stall != m_stall) begin errors++; $display("FAIL flush_stall sel=%0d: got %0d want %0d", s, o_stall, m_stall); end
        drive(1'b0, '0, 1'b1, 1'b1);
        tick(acc);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_no_emit sel=%0d: valid %b data %h want 0", s, o_valid, o_data); end
            tick(acc);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (o_flush != 1) begin errors++; $display("FAIL flush_empty sel=%0d: got %0d want 1", s, o_flush); end
        // A flush alongside a downstream transfer still counts as discarding a held beat.
        drive(1'b1, 64'd9, 1'b1, 1'b0);
        tick(acc);
        drive(1'b0, '0, 1'b1, 1'b1);
        checks++; if (o_valid !== 1'b1 || o_data !== 64'd9) begin errors++; $display("FAIL flush_xfer sel=%0d: valid %b data %h want 1 9", s, o_valid, o_data); end
        tick(acc);
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (o_flush != 2 || o_valid !== 1'b0) begin errors++; $display("FAIL flush_xfer_cnt sel=%0d: cnt %0d valid %b want 2 0", s, o_flush, o_valid); end
    endtask

    task automatic test_saturate();
        bit acc;
        sel = 1'b1;
        do_reset();
        drive(1'b1, 64'h55, 1'b0, 1'b0);
        tick(acc);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, '0, 1'b0, 1'b0);
            tick(acc);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (o_stall != 15) begin errors++; $display("FAIL stall_sat: got %0d want 15", o_stall); end
        checks++; if (o_ready !== 1'b0 || o_valid !== 1'b1) begin errors++; $display("FAIL comb_ready_lo: ready %b valid %b want 0 1", o_ready, o_valid); end
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL comb_ready_hi: got %b want 1", o_ready); end
        tick(acc);
    endtask

    task automatic test_async_reset(input bit s);
        bit acc;
        sel = s;
        do_reset();
        for (int i = 0; i < (s ? 1 : 2); i++) begin
            drive(1'b1, 64'h200 + 64'(i), 1'b0, 1'b0);
            tick(acc);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (o_ready !== 1'b0 || o_valid !== 1'b1) begin errors++; $display("FAIL areset_full sel=%0d: ready %b valid %b want 0 1", s, o_ready, o_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_data !== NOP || o_ready !== 1'b1 || o_stall != 0 || o_flush != 0) begin
            errors++; $display("FAIL areset_vals sel=%0d: v %b d %h r %b s %0d f %0d", s, o_valid, o_data, o_ready, o_stall, o_flush);
        end
        #10;
        rst_n = 1'b1;
        mq.delete(); m_stall = 0; m_flush = 0;
        @(posedge clk);
        #1;
        drive(1'b1, 64'hBEEF, 1'b1, 1'b0);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL areset_accept sel=%0d: ready %b want 1", s, o_ready); end
        tick(acc);
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (o_valid !== 1'b1 || o_data !== 64'hBEEF) begin errors++; $display("FAIL areset_first sel=%0d: valid %b data %h want 1 beef", s, o_valid, o_data); end
        tick(acc);
    endtask

    initial begin
        test_reset();
        test_single_beat(1'b0);
        test_single_beat(1'b1);
        test_skid_fill();
        test_stream(1'b0, 100);
        test_stream(1'b1, 100);
        test_flush(1'b0);
        test_flush(1'b1);
        test_saturate();
        test_async_reset(1'b0);
        test_async_reset(1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
